mc_controller: RTL and testbench

Multi-cycle MIPS control FSM that sequences the shared instruction/data memory, register file, ALU and PC over several cycles per instruction. It takes the opcode/funct from the instruction register and handshakes with memory through mem_ready. It drives all datapath enables and selects, replacing the single-cycle combinational controller in the multi-cycle datapath.

---
 rtl/mc_pkg.sv | 57 +++++
 rtl/mc_aludec.sv | 26 ++
 rtl/mc_controller.sv | 188 ++++++++++++++++++
 tb/tb_mc_controller.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multi-cycle MIPS controller
//   state_t         : 4-bit FSM state encoding
//   OP_* / FUNCT_*  : instruction fields decoded by the controller
//   ALUCTRL_*       : ALU operation codes
//   ALUSRCB_* / PCSRC_* : datapath mux select codes
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_RTYPE_EX = 4'd7,
    S_RTYPE_WB = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALUCTRL_ADD = 3'b010;
  localparam logic [2:0] ALUCTRL_SUB = 3'b110;
  localparam logic [2:0] ALUCTRL_AND = 3'b000;
  localparam logic [2:0] ALUCTRL_OR  = 3'b001;
  localparam logic [2:0] ALUCTRL_SLT = 3'b111;

  localparam logic [1:0] ALUSRCB_B       = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that wait on the memory handshake and are covered by the wait counter.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// rtl/mc_aludec.sv - R-type funct to ALU control decoder
//   funct   in  6  IR[5:0]
//   aluctrl out 3  ALU operation (add for unsupported funct)
//   legal   out 1  funct is one of add/sub/and/or/slt
module mc_aludec
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] aluctrl,
  output logic       legal
);

  always_comb begin
    aluctrl = ALUCTRL_ADD;
    legal   = 1'b1;
    case (funct)
      FUNCT_ADD: aluctrl = ALUCTRL_ADD;
      FUNCT_SUB: aluctrl = ALUCTRL_SUB;
      FUNCT_AND: aluctrl = ALUCTRL_AND;
      FUNCT_OR:  aluctrl = ALUCTRL_OR;
      FUNCT_SLT: aluctrl = ALUCTRL_SLT;
      default:   legal   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle MIPS control FSM
//   clk, rst          : clock, asynchronous active-low reset
//   ena               : run enable, sampled at instruction boundaries
//   op, funct, zero   : instruction fields and ALU zero flag
//   mem_ready         : memory handshake
//   mem_en .. pcen    : datapath enables and mux selects
//   instr_done, illegal_op, mem_timeout : one-cycle status pulses
module mc_controller
  import mc_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_en,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] aluctrl,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MEM_WAIT_MAX);

  state_t     state;
  state_t     state_next;
  logic [3:0] wait_cnt;
  logic [2:0] rtype_aluctrl;
  logic       funct_legal;
  logic       op_legal;
  logic       timeout;
  state_t     boundary_next;

  mc_aludec u_aludec (
    .funct   (funct),
    .aluctrl (rtype_aluctrl),
    .legal   (funct_legal)
  );

  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
      OP_RTYPE:                            op_legal = funct_legal;
      default:                             op_legal = 1'b0;
    endcase
  end

  assign timeout       = is_mem_state(state) && !mem_ready && (wait_cnt == WAIT_LIMIT);
  assign boundary_next = ena ? S_FETCH : S_IDLE;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (ena) state_next = S_FETCH;
      S_FETCH:    if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        if (!op_legal) state_next = boundary_next;
        else begin
          case (op)
            OP_LW, OP_SW: state_next = S_MEMADR;
            OP_BEQ:       state_next = S_BRANCH;
            OP_ADDI:      state_next = S_ADDI_EX;
            OP_J:         state_next = S_JUMP;
            default:      state_next = S_RTYPE_EX;
          endcase
        end
      end
      S_MEMADR:   state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    if (mem_ready) state_next = S_MEMWB;
      S_MEMWR:    if (mem_ready) state_next = boundary_next;
      S_RTYPE_EX: state_next = S_RTYPE_WB;
      S_ADDI_EX:  state_next = S_ADDI_WB;
      S_MEMWB, S_RTYPE_WB, S_ADDI_WB, S_BRANCH, S_JUMP:
                  state_next = boundary_next;
      default:    state_next = S_IDLE;
    endcase
    // An abandoned access restarts the fetch at the unchanged PC.
    if (timeout) state_next = S_FETCH;
  end

  // Counter restarts on any state change, on completion and after a timeout,
  // so a FETCH-to-FETCH timeout retry gets a full fresh budget.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (timeout || mem_ready || (state_next != state)) wait_cnt <= '0;
      else if (is_mem_state(state))                       wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_comb begin
    mem_en      = 1'b0;
    iord        = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = ALUSRCB_B;
    aluctrl     = ALUCTRL_AND;
    pcsrc       = PCSRC_ALU;
    pcen        = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    mem_timeout = timeout;
    case (state)
      S_FETCH: begin
        mem_en  = 1'b1;
        alusrcb = ALUSRCB_FOUR;
        aluctrl = ALUCTRL_ADD;
        irwrite = mem_ready;
        pcen    = mem_ready;
      end
      S_DECODE: begin
        alusrcb    = ALUSRCB_IMM_SH2;
        aluctrl    = ALUCTRL_ADD;
        illegal_op = !op_legal;
        instr_done = !op_legal;
      end
      S_MEMADR, S_ADDI_EX: begin
        alusrca = 1'b1;
        alusrcb = ALUSRCB_IMM;
        aluctrl = ALUCTRL_ADD;
      end
      S_MEMRD: begin
        mem_en = 1'b1;
        iord   = 1'b1;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_en     = 1'b1;
        iord       = 1'b1;
        memwrite   = !timeout;
        instr_done = mem_ready;
      end
      S_RTYPE_EX: begin
        alusrca = 1'b1;
        aluctrl = rtype_aluctrl;
      end
      S_RTYPE_WB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        aluctrl    = ALUCTRL_SUB;
        pcsrc      = PCSRC_ALUOUT;
        pcen       = zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pcsrc      = PCSRC_JUMP;
        pcen       = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - self-checking bench for mc_controller
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_en, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluctrl;
  logic       pcen, instr_done, illegal_op, mem_timeout;

  int n_chk = 0;
  int n_err = 0;
  logic [18:0] sb_q[$];

  mc_controller #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .ena(ena), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_en(mem_en), .iord(iord), .memwrite(memwrite),
    .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluctrl(aluctrl), .pcsrc(pcsrc),
    .pcen(pcen), .instr_done(instr_done), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  // Field order: mem_en iord memwrite irwrite regdst memtoreg regwrite alusrca
  //              alusrcb aluctrl pcsrc pcen instr_done illegal_op mem_timeout
  wire [18:0] got_v = {mem_en, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                       alusrcb, aluctrl, pcsrc, pcen, instr_done, illegal_op, mem_timeout};

  function automatic logic [18:0] ov(input logic me, io, mw, ir, rd, mt, rw, sa,
                                     input logic [1:0] sbv, input logic [2:0] ac,
                                     input logic [1:0] ps, input logic pe, dn, il, to);
    return {me, io, mw, ir, rd, mt, rw, sa, sbv, ac, ps, pe, dn, il, to};
  endfunction

  function automatic logic [18:0] e_fetch(input logic mr);
    return ov(1,0,0,mr,0,0,0,0, 2'b01, 3'b010, 2'b00, mr,0,0,0);
  endfunction
  function automatic logic [18:0] e_decode(input logic ill);
    return ov(0,0,0,0,0,0,0,0, 2'b11, 3'b010, 2'b00, 0,ill,ill,0);
  endfunction
  function automatic logic [18:0] e_adr();
    return ov(0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0,0,0,0);
  endfunction
  function automatic logic [18:0] e_memwr(input logic mr);
    return ov(1,1,1,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 0,mr,0,0);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected outputs, compare mid-cycle.
  task automatic step(input logic mr, input logic [18:0] exp, input string tag);
    logic [18:0] e;
    mem_ready = mr;
    sb_q.push_back(exp);
    @(negedge clk);
    e = sb_q.pop_front();
    check(tag, {13'd0, got_v}, {13'd0, e});
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [5:0] o, input logic [5:0] f, input logic ill,
                              input string nm);
    op = o;
    funct = f;
    step(1, e_fetch(1), {nm, " fetch"});
    step(1, e_decode(ill), {nm, " decode"});
  endtask

  task automatic do_lw();
    fetch_decode(6'b100011, 6'd0, 0, "lw");
    step(1, e_adr(), "lw memadr");
    step(1, ov(1,1,0,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 0,0,0,0), "lw memrd");
    step(1, ov(0,0,0,0,0,1,1,0, 2'b00, 3'b000, 2'b00, 0,1,0,0), "lw memwb");
  endtask

  task automatic do_rtype(input logic [5:0] f, input logic [2:0] ac, input logic drop_ena);
    fetch_decode(6'b000000, f, 0, "rtype");
    if (drop_ena) ena = 1'b0;
    step(1, ov(0,0,0,0,0,0,0,1, 2'b00, ac, 2'b00, 0,0,0,0), "rtype ex");
    step(1, ov(0,0,0,0,1,0,1,0, 2'b00, 3'b000, 2'b00, 0,1,0,0), "rtype wb");
  endtask

  logic [5:0] fn_tab[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] ac_tab[5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1);
  end

  initial begin
    #2;
    check("reset outputs", {13'd0, got_v}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    ena = 1'b1;
    step(1, '0, "idle after reset");

    do_lw();

    for (int i = 0; i < 5; i++) do_rtype(fn_tab[i], ac_tab[i], 0);

    fetch_decode(6'b001000, 6'd0, 0, "addi");
    step(1, e_adr(), "addi ex");
    step(1, ov(0,0,0,0,0,0,1,0, 2'b00, 3'b000, 2'b00, 0,1,0,0), "addi wb");

    for (int z = 1; z >= 0; z--) begin
      zero = 1'(z);
      fetch_decode(6'b000100, 6'd0, 0, "beq");
      step(1, ov(0,0,0,0,0,0,0,1, 2'b00, 3'b110, 2'b01, 1'(z),1,0,0), "beq branch");
    end
    zero = 1'b0;

    fetch_decode(6'b000010, 6'd0, 0, "j");
    step(1, ov(0,0,0,0,0,0,0,0, 2'b00, 3'b000, 2'b10, 1,1,0,0), "j jump");

    fetch_decode(6'b111111, 6'd0, 1, "illegal op");
    fetch_decode(6'b000000, 6'b111111, 1, "illegal funct");

    // sw with three wait cycles
    fetch_decode(6'b101011, 6'd0, 0, "sw");
    step(1, e_adr(), "sw memadr");
    for (int i = 0; i < 3; i++) step(0, e_memwr(0), "sw memwr wait");
    step(1, e_memwr(1), "sw memwr done");

    // sw that never completes: 15 tolerated wait cycles, then the timeout cycle
    fetch_decode(6'b101011, 6'd0, 0, "sw to");
    step(1, e_adr(), "sw to memadr");
    for (int i = 0; i < 15; i++) step(0, e_memwr(0), "sw to wait");
    step(0, ov(1,1,0,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 0,0,0,1), "sw timeout");
    step(0, e_fetch(0), "fetch after timeout");
    fetch_decode(6'b000010, 6'd0, 0, "j after to");
    step(1, ov(0,0,0,0,0,0,0,0, 2'b00, 3'b000, 2'b10, 1,1,0,0), "j after to jump");

    // ena dropped mid R-type: instruction finishes, then FSM parks in IDLE
    do_rtype(6'b100101, 3'b001, 1);
    step(1, '0, "idle after ena drop");
    step(1, '0, "idle held");
    ena = 1'b1;
    step(1, '0, "idle resuming");

    // asynchronous reset in the middle of a store
    fetch_decode(6'b101011, 6'd0, 0, "sw rst");
    step(1, e_adr(), "sw rst memadr");
    mem_ready = 1'b0;
    check("memwrite before rst", {31'd0, memwrite}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("memwrite async drop", {31'd0, memwrite}, 32'd0);
    check("outputs in rst", {13'd0, got_v}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1, '0, "idle after mid rst");
    do_lw();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
